// File: rtl/mppc_acq_sequencer.sv
// mppc_acq_sequencer: gated dark-count acquisition run controller with saturating accumulation
// Ports: clk/rst (sync, active-high); start/abort requests; gate_ticks/n_runs config latched on start;
// count_in from the external counter; counter_clr/counter_en drive that counter; busy/run_idx report
// progress; acc_out/overflow/result_valid present the total, released by result_ack.
module mppc_acq_sequencer #(
  parameter int CNT_W    = 27,
  parameter int ACC_W    = 32,
  parameter int TICK_DIV = 100000,
  parameter int SETTLE   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      gate_ticks,
  input  logic [7:0]       n_runs,
  input  logic [CNT_W-1:0] count_in,
  output logic             counter_clr,
  output logic             counter_en,
  output logic             busy,
  output logic [7:0]       run_idx,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ack
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam int MW = (ACC_W > CNT_W ? ACC_W : CNT_W) + 1;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_GATE, ST_SETTLE, ST_ACCUM, ST_DONE} state_t;
  state_t           state_q, state_d;
  logic [15:0]      gate_q, gate_d, tick_q, tick_d;
  logic [7:0]       runs_q, runs_d, run_idx_q, run_idx_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d, busy_c, carry;
  logic [MW-1:0]    sum;
  assign busy_c = state_q inside {ST_CLEAR, ST_GATE, ST_SETTLE, ST_ACCUM};
  assign sum    = MW'(acc_q) + MW'(count_in);
  // any bit at or above ACC_W means the total no longer fits
  assign carry  = |sum[MW-1:ACC_W];
  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    runs_d    = runs_q;
    run_idx_d = run_idx_q;
    tick_d    = tick_q;
    presc_d   = presc_q;
    settle_d  = '0;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: if (start && !abort) begin
        state_d   = ST_CLEAR;
        gate_d    = gate_ticks;
        runs_d    = n_runs == 8'd0 ? 8'd1 : n_runs;
        run_idx_d = '0;
        acc_d     = '0;
        ovf_d     = 1'b0;
      end
      ST_CLEAR: begin
        state_d = gate_q == 16'd0 ? ST_SETTLE : ST_GATE;
        tick_d  = '0;
        presc_d = '0;
      end
      ST_GATE: begin
        presc_d = presc_q == PW'(TICK_DIV - 1) ? '0 : presc_q + PW'(1);
        tick_d  = presc_q == PW'(TICK_DIV - 1) ? tick_q + 16'd1 : tick_q;
        state_d = presc_q == PW'(TICK_DIV - 1) && tick_q + 16'd1 == gate_q ? ST_SETTLE : ST_GATE;
      end
      ST_SETTLE: begin
        settle_d = settle_q + SW'(1);
        state_d  = settle_q == SW'(SETTLE - 1) ? ST_ACCUM : ST_SETTLE;
      end
      ST_ACCUM: begin
        acc_d     = carry ? '1 : sum[ACC_W-1:0];
        ovf_d     = ovf_q | carry;
        state_d   = run_idx_q + 8'd1 < runs_q ? ST_CLEAR : ST_DONE;
        run_idx_d = run_idx_q + 8'd1 < runs_q ? run_idx_q + 8'd1 : run_idx_q;
      end
      ST_DONE: if (result_ack) begin
        state_d   = ST_IDLE;
        run_idx_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    // abort discards whatever this cycle would have done, keeping the partial total
    if (abort && busy_c) begin
      state_d   = ST_IDLE;
      run_idx_d = '0;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gate_q    <= '0;
      runs_q    <= '0;
      run_idx_q <= '0;
      tick_q    <= '0;
      presc_q   <= '0;
      settle_q  <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      runs_q    <= runs_d;
      run_idx_q <= run_idx_d;
      tick_q    <= tick_d;
      presc_q   <= presc_d;
      settle_q  <= settle_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end
  assign counter_clr  = state_q == ST_CLEAR;
  assign counter_en   = state_q == ST_GATE;
  assign busy         = busy_c;
  assign result_valid = state_q == ST_DONE;
  assign run_idx      = run_idx_q;
  assign acc_out      = acc_q;
  assign overflow     = ovf_q;
endmodule
